reg_file_scoreboard: RTL



---
 rtl/reg_file_pkg.sv | 18 +
 rtl/reg_file_read_port.sv | 76 +++++++
 rtl/reg_file_scoreboard.sv | 136 +++++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg
//   Shared defaults and the address-legality helper for the register-file
//   scoreboard. The same rule decides whether an address can be written,
//   reserved, or read back as a real register.
package reg_file_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 4;
  localparam int NUM_REGS_DEF = 16;

  // True for addresses that map to real storage. With a hardwired zero
  // register, address 0 is treated like an unimplemented slot.
  function automatic logic is_writable(input int addr, input int num_regs,
                                       input int zero_reg0);
    return (addr < num_regs) && !((zero_reg0 != 0) && (addr == 0));
  endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// reg_file_read_port
//   One read port of the register file: address decode, masking of
//   unimplemented / zero-register addresses, same-cycle write forwarding and
//   an optional one-cycle output register.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   i_addr               read address
//   i_mem, i_busy        storage and busy bits, padded to 2**ADDR_W entries
//   i_wr_ok/_addr/_data  qualified write this cycle (already legality-checked)
//   i_rsv_ok/_addr       qualified reserve this cycle
//   o_data, o_busy       read result
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int NUM_REGS  = NUM_REGS_DEF,
  parameter int ZERO_REG0 = 0,
  parameter int BYPASS    = 1,
  parameter int READ_REG  = 0
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [ADDR_W-1:0]                       i_addr,
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]      i_mem,
  input  logic [(1<<ADDR_W)-1:0]                  i_busy,
  input  logic                                    i_wr_ok,
  input  logic [ADDR_W-1:0]                       i_wr_addr,
  input  logic [DATA_W-1:0]                       i_wr_data,
  input  logic                                    i_rsv_ok,
  input  logic [ADDR_W-1:0]                       i_rsv_addr,
  output logic [DATA_W-1:0]                       o_data,
  output logic                                    o_busy
);

  logic              w_valid;
  logic              w_fwd;
  logic [DATA_W-1:0] w_data;
  logic              w_busy;
  logic [DATA_W-1:0] r_data;
  logic              r_busy;

  assign w_valid = is_writable(int'(i_addr), NUM_REGS, ZERO_REG0);
  // i_wr_ok already implies a legal address, so forwarding never leaks data
  // onto an unimplemented or zero-register read.
  assign w_fwd   = (BYPASS != 0) && i_wr_ok && (i_wr_addr == i_addr);

  always_comb begin
    w_data = '0;
    w_busy = 1'b0;
    if (w_fwd) begin
      w_data = i_wr_data;
      // A same-edge reserve re-arms the register even though data lands now.
      w_busy = i_rsv_ok && (i_rsv_addr == i_addr);
    end else if (w_valid) begin
      w_data = i_mem[i_addr];
      w_busy = i_busy[i_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_busy <= 1'b0;
    end else begin
      r_data <= w_data;
      r_busy <= w_busy;
    end
  end

  // The output register is always present; with READ_REG=0 it is simply
  // unselected and trimmed away.
  assign o_data = (READ_REG != 0) ? r_data : w_data;
  assign o_busy = (READ_REG != 0) ? r_busy : w_busy;

endmodule

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard
//   2-read/1-write register file with per-register busy bits used for hazard
//   detection. Issue reserves a destination (sets busy), writeback writes data
//   and clears busy; operand fetch reads data plus busy on two ports.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   wr_en, wr_addr, wr_data       writeback
//   rsv_en, rsv_addr              reserve (set busy)
//   rd_addr_a/_b                  read addresses
//   rd_data_a/_b, rd_busy_a/_b    read data and busy status
//   busy_count                    number of busy registers
//   all_idle                      busy_count == 0
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int NUM_REGS  = NUM_REGS_DEF,
  parameter int ZERO_REG0 = 0,
  parameter int BYPASS    = 1,
  parameter int READ_REG  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_busy_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_b,
  output logic [ADDR_W:0]   busy_count,
  output logic              all_idle
);

  localparam int           DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = 1;

  logic [DATA_W-1:0]              r_mem [NUM_REGS];
  logic [NUM_REGS-1:0]            r_busy;
  logic [ADDR_W:0]                r_busy_count;

  logic                           w_wr_ok;
  logic                           w_rsv_ok;
  logic                           w_inc;
  logic                           w_dec;
  logic [DEPTH-1:0][DATA_W-1:0]   w_mem_full;
  logic [DEPTH-1:0]               w_busy_full;

  assign w_wr_ok  = wr_en  && is_writable(int'(wr_addr),  NUM_REGS, ZERO_REG0);
  assign w_rsv_ok = rsv_en && is_writable(int'(rsv_addr), NUM_REGS, ZERO_REG0);

  // Pad storage out to the full address space so any address indexes safely;
  // the padding is constant zero and masked again in the read ports.
  always_comb begin
    w_mem_full  = '0;
    w_busy_full = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_mem_full[i]  = r_mem[i];
      w_busy_full[i] = r_busy[i];
    end
  end

  // Reserve is applied after write so a same-address pair leaves busy set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_ok && (wr_addr == ADDR_W'(i))) begin
          r_mem[i]  <= wr_data;
          r_busy[i] <= 1'b0;
        end
        if (w_rsv_ok && (rsv_addr == ADDR_W'(i))) r_busy[i] <= 1'b1;
      end
    end
  end

  // Count tracks busy transitions only: a reserve of an idle register adds
  // one, a write that really frees a register removes one.
  assign w_inc = w_rsv_ok && !w_busy_full[rsv_addr];
  assign w_dec = w_wr_ok && w_busy_full[wr_addr] &&
                 !(w_rsv_ok && (rsv_addr == wr_addr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy_count <= '0;
    end else begin
      case ({w_inc, w_dec})
        2'b10:   r_busy_count <= r_busy_count + CNT_ONE;
        2'b01:   r_busy_count <= r_busy_count - CNT_ONE;
        default: r_busy_count <= r_busy_count;
      endcase
    end
  end

  assign busy_count = r_busy_count;
  assign all_idle   = (r_busy_count == '0);

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      assert ($countones(r_busy) == int'(r_busy_count))
        else $error("busy_count out of step with busy bits");
    end
  end
`endif

  reg_file_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
    .ZERO_REG0(ZERO_REG0), .BYPASS(BYPASS), .READ_REG(READ_REG)
  ) u_port_a (
    .clk(clk), .rst_n(rst_n), .i_addr(rd_addr_a),
    .i_mem(w_mem_full), .i_busy(w_busy_full),
    .i_wr_ok(w_wr_ok), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_rsv_ok(w_rsv_ok), .i_rsv_addr(rsv_addr),
    .o_data(rd_data_a), .o_busy(rd_busy_a)
  );

  reg_file_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
    .ZERO_REG0(ZERO_REG0), .BYPASS(BYPASS), .READ_REG(READ_REG)
  ) u_port_b (
    .clk(clk), .rst_n(rst_n), .i_addr(rd_addr_b),
    .i_mem(w_mem_full), .i_busy(w_busy_full),
    .i_wr_ok(w_wr_ok), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_rsv_ok(w_rsv_ok), .i_rsv_addr(rsv_addr),
    .o_data(rd_data_b), .o_busy(rd_busy_b)
  );

endmodule
